multi_cycle_counter: RTL and testbench
======================================

# multi_cycle_counter

Parametrised, multi-channel successor to the single-channel cycle counter: NUM_CH independent counters, each loaded with its own cycle count, run for exactly that many cycles, then report completion. Adds per-channel abort, auto-reload (periodic) mode, a live count readout and a sticky interrupt flag with write-1-to-clear. Sits behind the AXI4-Lite register slave; the slave drives the run/abort/clear strobes and reads status.

## Interface
- NUM_CH, 4, number of independent channels (1..16)
- CNT_W, 31, width of cycle count per channel (2..32)

- clk  input  1  system clock, all logic rising-edge
- reset_n  input  1  asynchronous active-low reset
- i_num_cycle  input  NUM_CH*CNT_W  per-channel cycle count N, channel c at [c*CNT_W +: CNT_W]
- i_run  input  NUM_CH  start strobe per channel
- i_auto_reload  input  NUM_CH  mode per channel, latched with i_run: 0 one-shot, 1 periodic
- i_abort  input  NUM_CH  abort strobe per channel
- i_irq_clr  input  NUM_CH  write-1-to-clear for o_irq
- o_idle  output  NUM_CH  channel in IDLE
- o_running  output  NUM_CH  channel in RUNNING
- o_done  output  NUM_CH  channel in DONE (one-cycle pulse per period)
- o_cnt  output  NUM_CH*CNT_W  current count per channel, same packing
- o_irq  output  NUM_CH  sticky completion flag
- o_irq_any  output  1  OR of o_irq

## Operation
- Per channel FSM, states IDLE, RUNNING, DONE; encoding 2'b00/01/10; illegal 2'b11 → IDLE next cycle.
- IDLE: i_run=1 and N≠0 → latch N and auto_reload bit, go RUNNING. i_run with N=0 ignored, stays IDLE.
- RUNNING: counter starts at 0, increments by 1 each cycle; when counter == latched N−1, counter → 0 and state → DONE. i_run ignored; latched N/mode not changed by new inputs.
- DONE: one cycle. Next: RUNNING (counter 0, same latched N) if auto_reload latched, else IDLE.
- i_abort: highest priority, any state → IDLE next cycle, counter 0, latched mode cleared, no DONE, no irq set. Abort and run same cycle: abort wins.
- o_cnt = counter value; 0 in IDLE and DONE. Compare uses CNT_W-bit arithmetic; N = 2^CNT_W−1 is legal, no wrap before terminal.
- o_irq[c] set on cycle channel enters DONE; cleared by i_irq_clr[c]; set and clear same cycle: set wins.
- Channels fully independent; no shared state except o_irq_any.

## Timing
- Reset: o_idle all 1, o_running 0, o_done 0, o_cnt 0, o_irq 0, o_irq_any 0; latched N and mode 0. Reset mid-run aborts immediately (asynchronous).
- i_run sampled at edge k → o_running high cycles k+1..k+N, o_done high cycle k+N+1, o_idle at k+N+2 (one-shot).
- Periodic: period N+1 cycles (N RUNNING + 1 DONE), o_done every N+1 cycles until abort.
- N=1: one RUNNING cycle, o_cnt stays 0.
- o_irq rises same cycle as o_done; o_irq_any same cycle (combinational OR).
- Abort sampled at edge k → o_idle at k+1.
- All outputs registered or decoded from registered state; no input-to-output combinational path except none.

## Structure
- Package cycle_counter_pkg: state constants S_IDLE/S_RUNNING/S_DONE, state width 2.
- Sub-module cycle_counter_ch: one channel (FSM, counter, latches, irq flag), parameter CNT_W; top generates NUM_CH instances and ORs irq.

## Test plan
- Reset: hold reset_n low 3 cycles → o_idle=4'hF, all else 0; deassert, idle stable 10 cycles.
- One-shot ch0 N=5: i_run[0] pulse → o_running[0] 5 cycles, o_cnt ch0 0..4, o_done[0] 1 cycle, o_irq[0]=1, o_idle[0] back; other channels untouched.
- Periodic ch1 N=3: o_done[1] every 4 cycles for 5 periods; i_abort[1] mid-RUNNING → IDLE next cycle, no further o_done.
- Boundaries: N=0 run → stays IDLE, no irq; N=1 → 1 RUNNING cycle; CNT_W=4 N=15 → 15 RUNNING cycles, no wrap; run during RUNNING ignored.
- Simultaneous: run+abort same cycle → stays IDLE; irq set and i_irq_clr same cycle → o_irq stays 1; clear next cycle → 0, o_irq_any 0.
- All 4 channels N=2,3,4,7 started same cycle → done at k+3,k+4,k+5,k+8; asynchronous reset asserted mid-run → all outputs reset values immediately.

Source files
------------

// File: rtl/multi_cycle_counter_pkg.sv
// Shared constants for the multi-channel cycle counter: per-channel FSM
// state encoding and its width.
package cycle_counter_pkg;

  localparam int STATE_W = 2;

  localparam logic [STATE_W-1:0] S_IDLE    = 2'b00;
  localparam logic [STATE_W-1:0] S_RUNNING = 2'b01;
  localparam logic [STATE_W-1:0] S_DONE    = 2'b10;

endpackage : cycle_counter_pkg

// File: rtl/multi_cycle_counter_if.sv
// Strobe/status bundle between the register slave (master side) and the
// counter block (slave side). Per-channel vectors, count fields packed CNT_W wide.
interface multi_cycle_counter_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 31
);

  logic [NUM_CH*CNT_W-1:0] i_num_cycle;
  logic [NUM_CH-1:0]       i_run;
  logic [NUM_CH-1:0]       i_auto_reload;
  logic [NUM_CH-1:0]       i_abort;
  logic [NUM_CH-1:0]       i_irq_clr;
  logic [NUM_CH-1:0]       o_idle;
  logic [NUM_CH-1:0]       o_running;
  logic [NUM_CH-1:0]       o_done;
  logic [NUM_CH*CNT_W-1:0] o_cnt;
  logic [NUM_CH-1:0]       o_irq;
  logic                    o_irq_any;

  modport master (
    output i_num_cycle, i_run, i_auto_reload, i_abort, i_irq_clr,
    input  o_idle, o_running, o_done, o_cnt, o_irq, o_irq_any
  );

  modport slave (
    input  i_num_cycle, i_run, i_auto_reload, i_abort, i_irq_clr,
    output o_idle, o_running, o_done, o_cnt, o_irq, o_irq_any
  );

endinterface : multi_cycle_counter_if

// File: rtl/multi_cycle_counter_ch.sv
// One counter channel: IDLE/RUNNING/DONE FSM, latched cycle count and mode,
// running counter and sticky completion flag.
module cycle_counter_ch
  import cycle_counter_pkg::*;
#(
  parameter int CNT_W = 31
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [CNT_W-1:0] num_cycle_i,
  input  logic             run_i,
  input  logic             auto_reload_i,
  input  logic             abort_i,
  input  logic             irq_clr_i,
  output logic             idle_o,
  output logic             running_o,
  output logic             done_o,
  output logic [CNT_W-1:0] cnt_o,
  output logic             irq_o
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [STATE_W-1:0] state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   num_q, num_d;
  logic               reload_q, reload_d;
  logic               irq_q, irq_d;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    num_d    = num_q;
    reload_d = reload_q;

    if (abort_i) begin
      state_d  = S_IDLE;
      cnt_d    = '0;
      reload_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          cnt_d = '0;
          if (run_i && (num_cycle_i != '0)) begin
            state_d  = S_RUNNING;
            num_d    = num_cycle_i;
            reload_d = auto_reload_i;
          end
        end
        S_RUNNING: begin
          // Terminal compare is N-1 so N = all-ones never needs the counter to wrap.
          if (cnt_q == (num_q - CNT_ONE)) begin
            state_d = S_DONE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        S_DONE: begin
          cnt_d   = '0;
          state_d = reload_q ? S_RUNNING : S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Entering DONE sets the flag; a simultaneous clear loses.
  always_comb begin
    irq_d = irq_q;
    if (state_d == S_DONE) begin
      irq_d = 1'b1;
    end else if (irq_clr_i) begin
      irq_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      num_q    <= '0;
      reload_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      num_q    <= num_d;
      reload_q <= reload_d;
      irq_q    <= irq_d;
    end
  end

  assign idle_o    = (state_q == S_IDLE);
  assign running_o = (state_q == S_RUNNING);
  assign done_o    = (state_q == S_DONE);
  assign cnt_o     = cnt_q;
  assign irq_o     = irq_q;

endmodule : cycle_counter_ch

// File: rtl/multi_cycle_counter.sv
// NUM_CH independent cycle counters behind one strobe/status interface;
// the only cross-channel logic is the interrupt OR.
module multi_cycle_counter
  import cycle_counter_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 31
) (
  input  logic                  clk,
  input  logic                  reset_n,
  multi_cycle_counter_if.slave  bus
);

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      cycle_counter_ch #(
        .CNT_W (CNT_W)
      ) u_ch (
        .clk           (clk),
        .reset_n       (reset_n),
        .num_cycle_i   (bus.i_num_cycle[gi*CNT_W +: CNT_W]),
        .run_i         (bus.i_run[gi]),
        .auto_reload_i (bus.i_auto_reload[gi]),
        .abort_i       (bus.i_abort[gi]),
        .irq_clr_i     (bus.i_irq_clr[gi]),
        .idle_o        (bus.o_idle[gi]),
        .running_o     (bus.o_running[gi]),
        .done_o        (bus.o_done[gi]),
        .cnt_o         (bus.o_cnt[gi*CNT_W +: CNT_W]),
        .irq_o         (bus.o_irq[gi])
      );
    end
  endgenerate

  assign bus.o_irq_any = |bus.o_irq;

endmodule : multi_cycle_counter

// File: tb/tb_multi_cycle_counter.sv
// Directed bench for multi_cycle_counter: 4 channels, 4-bit counts, hand-computed
// expectations checked one cycle at a time.
module tb_multi_cycle_counter;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 4;

  logic clk;
  logic reset_n;

  int pass_cnt  = 0;
  int total_cnt = 0;

  multi_cycle_counter_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut_if ();

  multi_cycle_counter #(
    .NUM_CH (NUM_CH),
    .CNT_W  (CNT_W)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (dut_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] cnt_of(input int c);
    return 32'(dut_if.o_cnt[c*CNT_W +: CNT_W]);
  endfunction

  task automatic set_n(input int c, input int n);
    dut_if.i_num_cycle[c*CNT_W +: CNT_W] = CNT_W'(n);
  endtask

  task automatic clear_all_irq();
    dut_if.i_irq_clr = '1;
    tick();
    dut_if.i_irq_clr = '0;
  endtask

  initial begin
    logic [3:0] exp_done;

    reset_n              = 1'b0;
    dut_if.i_num_cycle   = '0;
    dut_if.i_run         = '0;
    dut_if.i_auto_reload = '0;
    dut_if.i_abort       = '0;
    dut_if.i_irq_clr     = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_idle",    32'(dut_if.o_idle),    32'hF);
    chk("rst_running", 32'(dut_if.o_running), 32'h0);
    chk("rst_done",    32'(dut_if.o_done),    32'h0);
    chk("rst_cnt",     32'(dut_if.o_cnt),     32'h0);
    chk("rst_irq",     32'(dut_if.o_irq),     32'h0);
    chk("rst_irq_any", 32'(dut_if.o_irq_any), 32'h0);
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_stable", 32'(dut_if.o_idle), 32'hF);
    end

    // One-shot ch0, N=5
    set_n(0, 5);
    dut_if.i_run[0] = 1'b1;
    tick();
    dut_if.i_run[0] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      $display("oneshot ch0 cycle %0d cnt=%0d", i, cnt_of(0));
      chk("os_running", 32'(dut_if.o_running), 32'h1);
      chk("os_cnt", cnt_of(0), 32'(i));
      chk("os_others_idle", 32'(dut_if.o_idle[3:1]), 32'h7);
      tick();
    end
    chk("os_done", 32'(dut_if.o_done), 32'h1);
    chk("os_irq", 32'(dut_if.o_irq), 32'h1);
    chk("os_irq_any", 32'(dut_if.o_irq_any), 32'h1);
    chk("os_cnt_done", cnt_of(0), 32'h0);
    tick();
    chk("os_idle_back", 32'(dut_if.o_idle), 32'hF);
    chk("os_irq_sticky", 32'(dut_if.o_irq), 32'h1);
    clear_all_irq();
    chk("os_irq_cleared", 32'(dut_if.o_irq), 32'h0);

    // Periodic ch1, N=3: period 4
    set_n(1, 3);
    dut_if.i_auto_reload[1] = 1'b1;
    dut_if.i_run[1]         = 1'b1;
    tick();
    dut_if.i_run[1]         = 1'b0;
    dut_if.i_auto_reload[1] = 1'b0;
    for (int p = 0; p < 5; p++) begin
      for (int i = 0; i < 3; i++) begin
        chk("per_running", 32'(dut_if.o_running[1]), 32'h1);
        chk("per_cnt", cnt_of(1), 32'(i));
        tick();
      end
      $display("periodic ch1 period %0d done=%0b", p, dut_if.o_done[1]);
      chk("per_done", 32'(dut_if.o_done), 32'h2);
      tick();
    end
    tick();
    chk("per_cnt_pre_abort", cnt_of(1), 32'h1);
    dut_if.i_abort[1] = 1'b1;
    tick();
    dut_if.i_abort[1] = 1'b0;
    chk("abort_idle", 32'(dut_if.o_idle[1]), 32'h1);
    chk("abort_cnt", cnt_of(1), 32'h0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("abort_no_done", 32'(dut_if.o_done[1]), 32'h0);
    end
    clear_all_irq();

    // N=0 is ignored
    set_n(2, 0);
    dut_if.i_run[2] = 1'b1;
    tick();
    dut_if.i_run[2] = 1'b0;
    chk("n0_idle", 32'(dut_if.o_idle[2]), 32'h1);
    tick();
    chk("n0_no_irq", 32'(dut_if.o_irq[2]), 32'h0);

    // N=1: single RUNNING cycle at count 0
    set_n(2, 1);
    dut_if.i_run[2] = 1'b1;
    tick();
    dut_if.i_run[2] = 1'b0;
    chk("n1_running", 32'(dut_if.o_running[2]), 32'h1);
    chk("n1_cnt", cnt_of(2), 32'h0);
    tick();
    chk("n1_done", 32'(dut_if.o_done[2]), 32'h1);
    tick();
    chk("n1_idle", 32'(dut_if.o_idle[2]), 32'h1);

    // N=15 (all ones), with a re-run attempt mid-count
    set_n(3, 15);
    dut_if.i_run[3] = 1'b1;
    tick();
    dut_if.i_run[3] = 1'b0;
    for (int i = 0; i < 15; i++) begin
      chk("n15_running", 32'(dut_if.o_running[3]), 32'h1);
      chk("n15_cnt", cnt_of(3), 32'(i));
      if (i == 7) begin
        set_n(3, 2);
        dut_if.i_run[3] = 1'b1;
      end
      tick();
      dut_if.i_run[3] = 1'b0;
    end
    chk("n15_done", 32'(dut_if.o_done[3]), 32'h1);
    tick();
    chk("n15_idle", 32'(dut_if.o_idle[3]), 32'h1);
    clear_all_irq();

    // Run and abort together: abort wins
    set_n(0, 5);
    dut_if.i_run[0]   = 1'b1;
    dut_if.i_abort[0] = 1'b1;
    tick();
    dut_if.i_run[0]   = 1'b0;
    dut_if.i_abort[0] = 1'b0;
    chk("runabort_idle", 32'(dut_if.o_idle[0]), 32'h1);
    chk("runabort_running", 32'(dut_if.o_running[0]), 32'h0);

    // irq set and clear same cycle: set wins; clear next cycle
    set_n(2, 1);
    dut_if.i_run[2] = 1'b1;
    tick();
    dut_if.i_run[2]     = 1'b0;
    dut_if.i_irq_clr[2] = 1'b1;
    tick();
    chk("setclr_irq", 32'(dut_if.o_irq[2]), 32'h1);
    tick();
    dut_if.i_irq_clr[2] = 1'b0;
    chk("clr_irq", 32'(dut_if.o_irq), 32'h0);
    chk("clr_irq_any", 32'(dut_if.o_irq_any), 32'h0);

    // All channels together: N=2,3,4,7 -> done at k+3,k+4,k+5,k+8
    set_n(0, 2);
    set_n(1, 3);
    set_n(2, 4);
    set_n(3, 7);
    dut_if.i_run = 4'hF;
    tick();
    dut_if.i_run = 4'h0;
    for (int t = 1; t <= 8; t++) begin
      exp_done = {(t == 8), (t == 5), (t == 4), (t == 3)};
      $display("all-ch cycle k+%0d done=%b", t, dut_if.o_done);
      chk("all_done", 32'(dut_if.o_done), 32'(exp_done));
      tick();
    end
    chk("all_irq", 32'(dut_if.o_irq), 32'hF);
    clear_all_irq();

    // Asynchronous reset in the middle of a run
    dut_if.i_run = 4'hF;
    tick();
    dut_if.i_run = 4'h0;
    tick();
    chk("pre_arst_running", 32'(dut_if.o_running), 32'hF);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_idle",    32'(dut_if.o_idle),    32'hF);
    chk("arst_running", 32'(dut_if.o_running), 32'h0);
    chk("arst_done",    32'(dut_if.o_done),    32'h0);
    chk("arst_cnt",     32'(dut_if.o_cnt),     32'h0);
    chk("arst_irq_any", 32'(dut_if.o_irq_any), 32'h0);
    tick();
    reset_n = 1'b1;

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule : tb_multi_cycle_counter
